// File: rtl/run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl_if
// Purpose  : Control/status bundle between a run controller and its host.
// Revision : 1.0 - initial release
// ============================================================================
interface run_ctrl_if #(
    parameter int NUM_CORES = 1,
    parameter int CNT_W     = 32
);
    logic                 start;
    logic                 abort;
    logic [NUM_CORES-1:0] halt;
    logic [NUM_CORES-1:0] core_rst;
    logic                 running;
    logic                 done;
    logic                 timeout;
    logic [NUM_CORES-1:0] halted_mask;
    logic [CNT_W-1:0]     cycle_cnt;

    modport master (
        output start, abort, halt,
        input  core_rst, running, done, timeout, halted_mask, cycle_cnt
    );

    modport slave (
        input  start, abort, halt,
        output core_rst, running, done, timeout, halted_mask, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Purpose  : Sequences reset, run, drain and completion of a set of pipelines.
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int NUM_CORES    = 1,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 70,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    run_ctrl_if.slave   ctl
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HOLD  = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    // One counter serves both HOLD and DRAIN; it only needs to reach max-1.
    localparam int c_HD_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int c_HD_W   = (c_HD_MAX > 1) ? $clog2(c_HD_MAX) : 1;

    localparam logic [c_HD_W-1:0]    c_HOLD_LAST  = c_HD_W'(RESET_CYCLES - 1);
    localparam logic [c_HD_W-1:0]    c_DRAIN_LAST = c_HD_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [c_HD_W-1:0]    c_HD_ONE     = c_HD_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]     c_CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_CORES-1:0] c_ALL_CORES  = {NUM_CORES{1'b1}};

    logic [2:0]           r_state_q,       w_state_d;
    logic [c_HD_W-1:0]    r_hd_cnt_q,      w_hd_cnt_d;
    logic [CNT_W-1:0]     r_cycle_cnt_q,   w_cycle_cnt_d;
    logic [NUM_CORES-1:0] r_halted_mask_q, w_halted_mask_d;
    logic                 r_timeout_q,     w_timeout_d;

    logic [NUM_CORES-1:0] w_halt_merged;
    logic                 w_all_halted;

    assign w_halt_merged = r_halted_mask_q | ctl.halt;
    assign w_all_halted  = (w_halt_merged == c_ALL_CORES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= c_IDLE;
            r_hd_cnt_q      <= '0;
            r_cycle_cnt_q   <= '0;
            r_halted_mask_q <= '0;
            r_timeout_q     <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_hd_cnt_q      <= w_hd_cnt_d;
            r_cycle_cnt_q   <= w_cycle_cnt_d;
            r_halted_mask_q <= w_halted_mask_d;
            r_timeout_q     <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_hd_cnt_d      = r_hd_cnt_q;
        w_cycle_cnt_d   = r_cycle_cnt_q;
        w_halted_mask_d = r_halted_mask_q;
        w_timeout_d     = r_timeout_q;

        case (r_state_q)
            c_IDLE, c_DONE: begin
                if (ctl.start) begin
                    w_state_d       = c_HOLD;
                    w_hd_cnt_d      = '0;
                    w_cycle_cnt_d   = '0;
                    w_halted_mask_d = '0;
                    w_timeout_d     = 1'b0;
                end
            end

            c_HOLD: begin
                if (ctl.abort) begin
                    w_state_d = c_IDLE;
                end else if (r_hd_cnt_q == c_HOLD_LAST) begin
                    w_state_d  = c_RUN;
                    w_hd_cnt_d = '0;
                end else begin
                    w_hd_cnt_d = r_hd_cnt_q + c_HD_ONE;
                end
            end

            c_RUN: begin
                // Abort freezes counters so the host can inspect where the run stopped.
                if (ctl.abort) begin
                    w_state_d = c_IDLE;
                end else begin
                    w_cycle_cnt_d   = r_cycle_cnt_q + c_CNT_ONE;
                    w_halted_mask_d = w_halt_merged;
                    if (w_all_halted) begin
                        w_state_d  = (DRAIN_CYCLES == 0) ? c_DONE : c_DRAIN;
                        w_hd_cnt_d = '0;
                    end else if (r_cycle_cnt_q == c_CNT_LAST) begin
                        w_state_d   = c_DONE;
                        w_timeout_d = 1'b1;
                    end
                end
            end

            c_DRAIN: begin
                if (ctl.abort) begin
                    w_state_d = c_IDLE;
                end else if (r_hd_cnt_q == c_DRAIN_LAST) begin
                    w_state_d = c_DONE;
                end else begin
                    w_hd_cnt_d = r_hd_cnt_q + c_HD_ONE;
                end
            end

            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        ctl.core_rst = '0;
        ctl.running  = 1'b0;
        ctl.done     = 1'b0;
        case (r_state_q)
            c_IDLE, c_HOLD: ctl.core_rst = c_ALL_CORES;
            c_RUN:          ctl.running  = 1'b1;
            c_DONE:         ctl.done     = 1'b1;
            default:        ctl.core_rst = '0;
        endcase
    end

    assign ctl.timeout     = r_timeout_q;
    assign ctl.halted_mask = r_halted_mask_q;
    assign ctl.cycle_cnt   = r_cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_ctrl
// Purpose  : Directed self-checking bench for run_ctrl across four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    run_ctrl_if #(.NUM_CORES(1), .CNT_W(32)) if0 ();
    run_ctrl_if #(.NUM_CORES(2), .CNT_W(32)) if1 ();
    run_ctrl_if #(.NUM_CORES(1), .CNT_W(32)) if2 ();
    run_ctrl_if #(.NUM_CORES(2), .CNT_W(32)) if3 ();

    run_ctrl u0 (.clk(clk), .rst(rst), .ctl(if0.slave));
    run_ctrl #(.NUM_CORES(2), .RESET_CYCLES(3)) u1 (.clk(clk), .rst(rst), .ctl(if1.slave));
    run_ctrl #(.MAX_CYCLES(8)) u2 (.clk(clk), .rst(rst), .ctl(if2.slave));
    run_ctrl #(.NUM_CORES(2), .DRAIN_CYCLES(0)) u3 (.clk(clk), .rst(rst), .ctl(if3.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (if0.core_rst !== 1'b1 || if0.running !== 1'b0 || if0.done !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl actual=%b%b%b required=100", if0.core_rst, if0.running, if0.done); end
        checks++; if (if0.timeout !== 1'b0 || if0.halted_mask !== 1'b0 || if0.cycle_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_state actual=%b %b %0d required=0 0 0", if0.timeout, if0.halted_mask, if0.cycle_cnt); end
        checks++; if (if1.core_rst !== 2'b11) begin
            failures++; $display("FAIL reset_core_rst2 actual=%b required=11", if1.core_rst); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (if0.core_rst !== 1'b1 || if0.running !== 1'b0 || if0.done !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset actual=%b%b%b required=100", if0.core_rst, if0.running, if0.done); end
    endtask

    task automatic test_timeout();
        int n;
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        checks++; if (if0.core_rst !== 1'b1 || if0.running !== 1'b0) begin
            failures++; $display("FAIL to_hold actual=%b%b required=10", if0.core_rst, if0.running); end
        tick();
        checks++; if (if0.core_rst !== 1'b0 || if0.running !== 1'b1 || if0.cycle_cnt !== 32'd0) begin
            failures++; $display("FAIL to_run actual=%b%b cnt=%0d required=01 cnt=0", if0.core_rst, if0.running, if0.cycle_cnt); end
        n = 0;
        while (if0.running === 1'b1 && n < 200) begin n++; tick(); end
        checks++; if (n !== 70) begin
            failures++; $display("FAIL to_run_len actual=%0d required=70", n); end
        checks++; if (if0.done !== 1'b1 || if0.timeout !== 1'b1 || if0.core_rst !== 1'b0) begin
            failures++; $display("FAIL to_done actual=%b%b%b required=110", if0.done, if0.timeout, if0.core_rst); end
        checks++; if (if0.cycle_cnt !== 32'd70) begin
            failures++; $display("FAIL to_cnt actual=%0d required=70", if0.cycle_cnt); end
    endtask

    task automatic test_halt_drain();
        if1.start = 1'b1; tick(); if1.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (if1.core_rst !== 2'b11 || if1.running !== 1'b0) begin
                failures++; $display("FAIL hd_hold%0d actual=%b%b required=110", i, if1.core_rst, if1.running); end
            tick();
        end
        checks++; if (if1.running !== 1'b1 || if1.core_rst !== 2'b00 || if1.cycle_cnt !== 32'd0) begin
            failures++; $display("FAIL hd_run actual=%b%b cnt=%0d required=100 cnt=0", if1.running, if1.core_rst, if1.cycle_cnt); end
        repeat (5) tick();
        if1.halt = 2'b01; tick(); if1.halt = 2'b00;
        checks++; if (if1.halted_mask !== 2'b01 || if1.running !== 1'b1 || if1.cycle_cnt !== 32'd6) begin
            failures++; $display("FAIL hd_mask01 actual=%b %b %0d required=01 1 6", if1.halted_mask, if1.running, if1.cycle_cnt); end
        repeat (3) tick();
        if1.halt = 2'b10; tick(); if1.halt = 2'b00;
        checks++; if (if1.halted_mask !== 2'b11 || if1.running !== 1'b0 || if1.done !== 1'b0 || if1.cycle_cnt !== 32'd10) begin
            failures++; $display("FAIL hd_drain actual=%b %b%b %0d required=11 00 10", if1.halted_mask, if1.running, if1.done, if1.cycle_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (if1.done !== 1'b0 || if1.running !== 1'b0) begin
                failures++; $display("FAIL hd_drain_len%0d actual=%b%b required=00", i, if1.done, if1.running); end
            tick();
        end
        checks++; if (if1.done !== 1'b1 || if1.timeout !== 1'b0 || if1.cycle_cnt !== 32'd10 || if1.core_rst !== 2'b00) begin
            failures++; $display("FAIL hd_done actual=%b%b %0d %b required=10 10 00", if1.done, if1.timeout, if1.cycle_cnt, if1.core_rst); end
    endtask

    task automatic test_budget_tie();
        if2.start = 1'b1; tick(); if2.start = 1'b0;
        tick();
        repeat (7) tick();
        checks++; if (if2.running !== 1'b1 || if2.cycle_cnt !== 32'd7) begin
            failures++; $display("FAIL tie_pre actual=%b %0d required=1 7", if2.running, if2.cycle_cnt); end
        if2.halt = 1'b1; tick(); if2.halt = 1'b0;
        checks++; if (if2.running !== 1'b0 || if2.done !== 1'b0 || if2.timeout !== 1'b0 || if2.cycle_cnt !== 32'd8) begin
            failures++; $display("FAIL tie_drain actual=%b%b%b %0d required=000 8", if2.running, if2.done, if2.timeout, if2.cycle_cnt); end
        repeat (4) tick();
        checks++; if (if2.done !== 1'b1 || if2.timeout !== 1'b0) begin
            failures++; $display("FAIL tie_done actual=%b%b required=10", if2.done, if2.timeout); end
    endtask

    task automatic test_abort();
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        checks++; if (if0.timeout !== 1'b0 || if0.cycle_cnt !== 32'd0 || if0.done !== 1'b0) begin
            failures++; $display("FAIL restart_clear actual=%b %0d %b required=0 0 0", if0.timeout, if0.cycle_cnt, if0.done); end
        tick();
        repeat (12) tick();
        if0.abort = 1'b1; if0.start = 1'b1; tick(); if0.abort = 1'b0; if0.start = 1'b0;
        checks++; if (if0.core_rst !== 1'b1 || if0.running !== 1'b0 || if0.done !== 1'b0 || if0.cycle_cnt !== 32'd12) begin
            failures++; $display("FAIL abort_idle actual=%b%b%b %0d required=100 12", if0.core_rst, if0.running, if0.done, if0.cycle_cnt); end
        repeat (2) tick();
        checks++; if (if0.running !== 1'b0 || if0.core_rst !== 1'b1 || if0.cycle_cnt !== 32'd12) begin
            failures++; $display("FAIL abort_start_ignored actual=%b%b %0d required=01 12", if0.running, if0.core_rst, if0.cycle_cnt); end
    endtask

    task automatic test_rst_drain();
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        tick();
        repeat (2) tick();
        if0.halt = 1'b1; tick(); if0.halt = 1'b0;
        checks++; if (if0.running !== 1'b0 || if0.done !== 1'b0 || if0.halted_mask !== 1'b1 || if0.cycle_cnt !== 32'd3) begin
            failures++; $display("FAIL rd_drain actual=%b%b %b %0d required=00 1 3", if0.running, if0.done, if0.halted_mask, if0.cycle_cnt); end
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (if0.core_rst !== 1'b1 || if0.running !== 1'b0 || if0.done !== 1'b0 || if0.timeout !== 1'b0
                      || if0.halted_mask !== 1'b0 || if0.cycle_cnt !== 32'd0) begin
            failures++; $display("FAIL rd_reset actual=%b%b%b%b %b %0d required=1000 0 0", if0.core_rst, if0.running,
                                 if0.done, if0.timeout, if0.halted_mask, if0.cycle_cnt); end
        tick();
        checks++; if (if0.core_rst !== 1'b1 || if0.running !== 1'b0 || if0.done !== 1'b0) begin
            failures++; $display("FAIL rd_idle actual=%b%b%b required=100", if0.core_rst, if0.running, if0.done); end
        if0.start = 1'b1; tick(); if0.start = 1'b0;
        tick();
        checks++; if (if0.running !== 1'b1 || if0.cycle_cnt !== 32'd0) begin
            failures++; $display("FAIL rd_rerun actual=%b %0d required=1 0", if0.running, if0.cycle_cnt); end
        repeat (4) tick();
        checks++; if (if0.cycle_cnt !== 32'd4 || if0.halted_mask !== 1'b0) begin
            failures++; $display("FAIL rd_rerun_cnt actual=%0d %b required=4 0", if0.cycle_cnt, if0.halted_mask); end
        if0.abort = 1'b1; tick(); if0.abort = 1'b0;
    endtask

    task automatic test_drain_zero();
        if3.start = 1'b1; tick(); if3.start = 1'b0;
        tick();
        repeat (3) tick();
        if3.halt = 2'b11; tick(); if3.halt = 2'b00;
        checks++; if (if3.done !== 1'b1 || if3.running !== 1'b0 || if3.cycle_cnt !== 32'd4 || if3.timeout !== 1'b0
                      || if3.halted_mask !== 2'b11) begin
            failures++; $display("FAIL dz_done actual=%b%b %0d %b %b required=10 4 0 11", if3.done, if3.running,
                                 if3.cycle_cnt, if3.timeout, if3.halted_mask); end
        tick();
        checks++; if (if3.done !== 1'b1) begin
            failures++; $display("FAIL dz_persist actual=%b required=1", if3.done); end
        if3.start = 1'b1; if3.halt = 2'b11; tick(); if3.start = 1'b0;
        checks++; if (if3.done !== 1'b0 || if3.core_rst !== 2'b11 || if3.cycle_cnt !== 32'd0
                      || if3.halted_mask !== 2'b00 || if3.timeout !== 1'b0) begin
            failures++; $display("FAIL dz_restart actual=%b %b %0d %b %b required=0 11 0 00 0", if3.done, if3.core_rst,
                                 if3.cycle_cnt, if3.halted_mask, if3.timeout); end
        tick(); if3.halt = 2'b00;
        checks++; if (if3.running !== 1'b1 || if3.halted_mask !== 2'b00) begin
            failures++; $display("FAIL dz_hold_halt_ignored actual=%b %b required=1 00", if3.running, if3.halted_mask); end
    endtask

    initial begin
        if0.start = 1'b0; if0.abort = 1'b0; if0.halt = '0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.halt = '0;
        if2.start = 1'b0; if2.abort = 1'b0; if2.halt = '0;
        if3.start = 1'b0; if3.abort = 1'b0; if3.halt = '0;
        test_reset();
        test_timeout();
        test_halt_drain();
        test_budget_tie();
        test_abort();
        test_rst_drain();
        test_drain_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 1: number of controlled pipeline instances; legal range 1..16.
REQ-002 Parameter RESET_CYCLES, default 1: cycles the core reset is held after start; must be at least 1.
REQ-003 Parameter MAX_CYCLES, default 70: run-cycle budget before timeout; must be at least 1.
REQ-004 Parameter DRAIN_CYCLES, default 4: cycles waited after all cores halt before done; 0 is legal.
REQ-005 Parameter CNT_W, default 32: cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to begin a run; honoured in IDLE and DONE only.
REQ-009 abort  input  1  stop the run immediately; honoured in HOLD, RUN and DRAIN.
REQ-010 halt  input  NUM_CORES  per-core halt indication; level or pulse.
REQ-011 core_rst  output  NUM_CORES  reset to each pipeline; active high.
REQ-012 running  output  1  high while the FSM is in RUN.
REQ-013 done  output  1  high while the FSM is in DONE.
REQ-014 timeout  output  1  sticky flag: the last run ended by budget exhaustion.
REQ-015 halted_mask  output  NUM_CORES  sticky per-core halt record for the current run.
REQ-016 cycle_cnt  output  CNT_W  number of RUN cycles elapsed in the current run.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, RUN, DRAIN and DONE, all registered, with every output decoded from registered state only.
REQ-018 core_rst SHALL be all ones in IDLE and HOLD, and all zeros in RUN, DRAIN and DONE.
REQ-019 IDLE or DONE with start=1 SHALL go to HOLD and, on that same edge, clear cycle_cnt, halted_mask, timeout and the hold/drain counter.
REQ-020 HOLD SHALL last exactly RESET_CYCLES cycles, then go to RUN.
REQ-021 In RUN, cycle_cnt SHALL increment by 1 per cycle; it SHALL be frozen in all other states except where REQ-019 clears it.
REQ-022 In RUN, halted_mask SHALL become halted_mask OR halt on each edge; halt SHALL be ignored in every other state.
REQ-023 In RUN, if (halted_mask OR halt) is all ones, the next state SHALL be DRAIN; if DRAIN_CYCLES = 0, it SHALL go straight to DONE.
REQ-024 In RUN, if cycle_cnt = MAX_CYCLES-1 and the cores are not all halted, the next state SHALL be DONE with timeout=1 and cycle_cnt=MAX_CYCLES.
REQ-025 If all cores halt on the same edge that the budget expires, halt SHALL win: DRAIN/DONE is taken with timeout=0.
REQ-026 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then go to DONE.
REQ-027 DONE SHALL persist until start, which restarts per REQ-019, or until rst.
REQ-028 abort in HOLD, RUN or DRAIN SHALL go to IDLE on the next edge; cycle_cnt and halted_mask SHALL be retained for inspection and timeout SHALL be left unchanged.
REQ-029 If abort and start are both high, abort SHALL take priority; start SHALL be ignored in HOLD, RUN and DRAIN.
REQ-030 cycle_cnt SHALL never wrap; REQ-024 guarantees termination before overflow.

Reset
REQ-031 A clock edge with rst=1 SHALL force the following, overriding start and abort in any state, including mid-run: state=IDLE, core_rst all ones, running=0, done=0, timeout=0, halted_mask=0, cycle_cnt=0, internal counters=0.
REQ-032 After rst is released, the block SHALL stay in IDLE until start is seen.

Verification
REQ-033 Defaults; rst for 2 cycles, start pulse, halt never asserted -> core_rst high for exactly 1 cycle after start; running for 70 cycles; then done=1, timeout=1, cycle_cnt=70.
REQ-034 NUM_CORES=2, RESET_CYCLES=3; halt[0] pulses at RUN cycle 5, halt[1] pulses at cycle 9 -> halted_mask=01 then 11; DRAIN lasts 4 cycles; done=1, timeout=0, cycle_cnt=10.
REQ-035 MAX_CYCLES=8; halt rises on the edge where cycle_cnt=7 -> DRAIN entered, timeout=0, cycle_cnt=8.
REQ-036 abort in RUN at cycle_cnt=12 -> next cycle IDLE with core_rst all ones, cycle_cnt=12; a start pulse in the same cycle as abort is ignored.
REQ-037 rst asserted in DRAIN -> next cycle all outputs at reset values; a later start runs a clean second run with cycle_cnt starting from 0.
REQ-038 DRAIN_CYCLES=0, all cores halt at RUN cycle 3 -> DONE on the next edge, done=1, cycle_cnt=4; start in DONE -> HOLD with flags cleared.
